// File: rtl/ram_arb_pkg.sv
// Shared types for the two-client RAM port arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (client 0 wins ties).
package ram_arb_pkg;

  localparam int unsigned N_CLIENTS = 2;

  // Index of the client that owns the command in flight.
  typedef logic [0:0] owner_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational winner select for two requesters.
// Build option: RAM_ARB_FIXED_PRIO_EN reduces this to a priority encoder (no last input).
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic [N_CLIENTS-1:0] req,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  owner_t               last,
`endif
  output logic                 valid,
  output owner_t               win
);

  // Pick the winner among the active requests.
  always_comb begin
    valid = |req;
    win   = owner_t'(0);
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (!req[0] && req[1]) win = owner_t'(1);
`else
    // On a tie the client that did not win last time goes next.
    if (req[0] && req[1]) win = ~last;
    else if (req[1])      win = owner_t'(1);
`endif
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-client arbiter and sequencer in front of a single-port register-array RAM.
// Commands go out as one-cycle read/write strobes; reads return with an rvalid pulse.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CLIENTS-1:0]        req,
  input  logic [N_CLIENTS-1:0]        we,
  input  logic [N_CLIENTS*ADDR_W-1:0] addr,
  input  logic [N_CLIENTS*DATA_W-1:0] wdata,
  output logic [N_CLIENTS-1:0]        gnt,
  output logic [N_CLIENTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        ram_read_rq,
  output logic                        ram_write_rq,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata
);

  arb_state_e state_q, state_d;
  owner_t     owner_q, owner_d;
  logic       cmd_we_q, cmd_we_d;

  // ram_addr_q/ram_wdata_q double as the latched command address and data.
  logic [N_CLIENTS-1:0] gnt_q, gnt_d;
  logic [N_CLIENTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;

  logic   win_valid;
  owner_t win;

`ifndef RAM_ARB_FIXED_PRIO_EN
  owner_t last_q, last_d;
`endif

  rr_arbiter_2 u_arb (
    .req   (req),
`ifndef RAM_ARB_FIXED_PRIO_EN
    .last  (last_q),
`endif
    .valid (win_valid),
    .win   (win)
  );

  // Next-state and registered-output logic; strobes are set on entry to ISSUE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          owner_d     = win;
          cmd_we_d    = we[win];
          ram_addr_d  = addr[win*ADDR_W +: ADDR_W];
          ram_wdata_d = wdata[win*DATA_W +: DATA_W];
          gnt_d[win]  = 1'b1;
          wr_d        = we[win];
          rd_d        = ~we[win];
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_d      = win;
`endif
          state_d     = StIssue;
        end
      end
      StIssue: begin
        state_d = cmd_we_q ? StIdle : StResp;
      end
      StResp: begin
        // RAM read data is valid in this cycle; hand it back to the owner.
        rdata_d           = ram_rdata;
        rvalid_d[owner_q] = 1'b1;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= owner_t'(0);
      cmd_we_q    <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q      <= owner_t'(1);
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign ram_read_rq  = rd_q;
  assign ram_write_rq = wr_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios then randomized clients, all checked
// against a transaction-level schedule model and a behavioural RAM.
module tb_ram_port_arbiter;

  localparam int AW = 2;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          ram_read_rq;
  logic          ram_write_rq;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .ram_read_rq  (ram_read_rq),
    .ram_write_rq (ram_write_rq),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Behavioural RAM: synchronous write, read data valid the cycle after the strobe.
  logic [DW-1:0] ram_mem [4];
  initial for (int i = 0; i < 4; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_write_rq) ram_mem[ram_addr] <= ram_wdata;
    if (ram_read_rq)  ram_rdata <= ram_mem[ram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Client command state (held until granted).
  logic          c_req [2];
  logic          c_we  [2];
  logic [AW-1:0] c_addr[2];
  logic [DW-1:0] c_wd  [2];
  int            mode;  // 0: drop req after gnt, 1: random, 2: hold same command

  // Reference model state, in terms of sampling edges.
  int            edge_n = 0;
  int            free_e = 0;
  int            m_last = 1;
  int            rv_e   = -1;
  int            rv_own = 0;
  logic [DW-1:0] rv_dat = '0;
  logic [DW-1:0] m_mem [4];
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    exp_gnt, exp_rv;
  logic          exp_rd, exp_wr;

  task automatic new_cmd(input int i);
    c_req[i]  = 1'b1;
    c_we[i]   = 1'($urandom_range(0, 1));
    c_addr[i] = AW'($urandom_range(0, 3));
    c_wd[i]   = DW'($urandom_range(0, 3));
  endtask

  task automatic step();
    int w;
    req   = {c_req[1], c_req[0]};
    we    = {c_we[1], c_we[0]};
    addr  = {c_addr[1], c_addr[0]};
    wdata = {c_wd[1], c_wd[0]};
    @(posedge clk);
    edge_n++;
    exp_gnt = '0; exp_rv = '0; exp_rd = 1'b0; exp_wr = 1'b0;
    if (rst) begin
      free_e = edge_n + 1; m_last = 1; rv_e = -1;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      if (edge_n == rv_e) begin
        exp_rv[rv_own] = 1'b1;
        m_rdata = rv_dat;
      end
      if (edge_n >= free_e && (c_req[0] || c_req[1])) begin
        if (c_req[0] && c_req[1]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = 1 - m_last;
`endif
        end else begin
          w = c_req[0] ? 0 : 1;
        end
        m_last = w;
        exp_gnt[w] = 1'b1;
        m_addr = c_addr[w];
        m_wdata = c_wd[w];
        if (c_we[w]) begin
          exp_wr = 1'b1;
          m_mem[c_addr[w]] = c_wd[w];
          free_e = edge_n + 2;
        end else begin
          exp_rd = 1'b1;
          rv_e = edge_n + 2; rv_own = w; rv_dat = m_mem[c_addr[w]];
          free_e = edge_n + 3;
        end
      end
    end
    #1;
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("rvalid", 32'(rvalid), 32'(exp_rv));
    check_eq("ram_read_rq", 32'(ram_read_rq), 32'(exp_rd));
    check_eq("ram_write_rq", 32'(ram_write_rq), 32'(exp_wr));
    check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
    check_eq("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    check_eq("rdata", 32'(rdata), 32'(m_rdata));
    check_eq("strobe_excl", 32'(ram_read_rq & ram_write_rq), 32'(0));
    check_eq("onehot0", 32'($onehot0(gnt) && $onehot0(rvalid)), 32'(1));
    // Client reactions, driven from the bench's own view of grants.
    for (int i = 0; i < 2; i++) begin
      if (exp_gnt[i]) begin
        if (mode == 0) c_req[i] = 1'b0;
        else if (mode == 1) begin
          if ($urandom_range(0, 2) == 0) c_req[i] = 1'b0;
          else new_cmd(i);
        end
      end else if (mode == 1 && !c_req[i] && $urandom_range(0, 2) == 0) begin
        new_cmd(i);
      end
    end
    if (mode == 1) rst = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    int found;
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wd[i] = '0;
    end
    mode = 0;

    // Reset state.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // Client 0 writes addr 2 data 3.
    c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 2'd2; c_wd[0] = 2'd3;
    repeat (4) step();

    // Client 1 reads addr 2 back.
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 2'd2;
    repeat (5) step();
    check_eq("readback_rdata", 32'(rdata), 32'(3));

    // Both clients hold reads continuously: grants alternate (or stay on 0 when fixed).
    mode = 2;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 2'd1;
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 2'd3;
    repeat (14) step();
    mode = 0;
    c_req[0] = 1'b0; c_req[1] = 1'b0;
    repeat (4) step();

    // Client 0 drops req in the ISSUE cycle; command still completes once.
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 2'd2;
    repeat (5) step();

    // Reset arriving in the RESP cycle of a read drops the response.
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 2'd2;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      if (exp_gnt[1]) found = 1;
    end
    check_eq("resp_rst_gnt_seen", 32'(found), 32'(1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Randomized clients with occasional reset.
    mode = 1;
    repeat (800) step();
    mode = 0;
    rst = 1'b0;
    c_req[0] = 1'b0; c_req[1] = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
